// File: rtl/simple_pkg.sv
// Shared types and constants for the 16-bit SIMPLE core.
package simple_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int INST_W_DEF = 16;

  // op=3, ty=7: decodes to an instruction with no side effects
  localparam logic [15:0] NOP_INST  = 16'hC070;
  localparam logic [15:0] HALT_INST = 16'hC0F0;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_id_reg
  import simple_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic [INST_W-1:0] inst_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic [INST_W-1:0] inst_id,
  output logic [PC_W-1:0]   pc_id,
  output logic              valid_id
);

  // A bubble leaves pc_id untouched; only the instruction and valid flag change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_id  <= INST_W'(NOP_INST);
      pc_id    <= '0;
      valid_id <= 1'b0;
    end else if (bubble) begin
      inst_id  <= INST_W'(NOP_INST);
      valid_id <= 1'b0;
    end else if (load) begin
      inst_id  <= inst_in;
      pc_id    <= pc_in;
      valid_id <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, stall/flush/halt control and IF/ID register.
// Optional perf counters (perf_fetched, perf_stall) enabled by FETCH_PERF_EN.
module fetch_stage
  import simple_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              is_halt,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_id,
  output logic [PC_W-1:0]   pc_id,
  output logic              valid_id,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic              halted
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  logic            ifid_load, ifid_bubble;
  logic            fetch_ok, stall_cnt_en;

  assign pc_inc = pc + PC_W'(1);
  assign halted = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    state_nxt = RUN;
      RUN:     if (!flush && is_halt && valid_id) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FILL;
    endcase
  end

  // imem_addr always equals the pc for the next cycle, so imem_rdata matches pc in RUN.
  always_comb begin
    pc_nxt       = pc;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    fetch_ok     = 1'b0;
    stall_cnt_en = 1'b0;
    case (state)
      FILL: ifid_bubble = 1'b1;
      RUN: begin
        stall_cnt_en = stall && !flush;
        if (flush) begin
          pc_nxt      = branch_target;
          ifid_bubble = 1'b1;
        end else if (is_halt && valid_id) begin
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          pc_nxt    = pc_inc;
          ifid_load = 1'b1;
          fetch_ok  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_nxt;
  end

  if_id_reg #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .inst_in  (imem_rdata),
    .pc_in    (pc_inc),
    .inst_id  (inst_id),
    .pc_id    (pc_id),
    .valid_id (valid_id)
  );

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_ok)     perf_fetched <= sat_inc(perf_fetched);
      if (stall_cnt_en) perf_stall   <= sat_inc(perf_stall);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = fetch_ok ^ stall_cnt_en;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit SIMPLE core; feeds `inst_id` and `pc_id` directly to the decode controller.
- Owns the PC and drives a synchronous-read instruction memory with 1-cycle latency.
- Handles stall from the hazard unit, flush/redirect on taken branch, and halt once decode reports `is_halt`.

Parameters:
- PC_W, 16, PC and instruction-memory word-address width.
- INST_W, 16, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous active-high reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- flush  in  1  taken branch resolved this cycle; redirect the PC.
- branch_target  in  PC_W  redirect address, sampled when flush=1.
- is_halt  in  1  decode controller's halt flag for the current `inst_id`.
- imem_addr  out  PC_W  combinational address to instruction memory (next PC).
- imem_rdata  in  INST_W  memory data for the address presented on the previous edge.
- inst_id  out  INST_W  registered instruction to decode.
- pc_id  out  PC_W  registered PC+1 of `inst_id`; branch base address.
- valid_id  out  1  `inst_id` is a real instruction, not a bubble.
- halted  out  1  core halted; fetch frozen.

Behaviour:
- Reset (asynchronous): pc=RESET_PC, state=FILL, inst_id=NOP_INST (16'hC070: op=3, ty=7, no side effects in decode), pc_id=0, valid_id=0, halted=0.
- States: FILL, RUN, HALTED.
- FILL:
  - imem_addr=pc (RESET_PC); pc unchanged; IF/ID loads the bubble.
  - Next state: RUN. Gives the memory one cycle to return RESET_PC's word.
- RUN, priority order:
  1. flush
     - imem_addr=branch_target; pc<=branch_target.
     - IF/ID loads the bubble (inst_id=NOP_INST, valid_id=0).
     - flush overrides stall and halt in the same cycle.
  2. is_halt && valid_id
     - state<=HALTED; halted<=1; pc held; IF/ID loads the bubble.
     - The halt instruction itself has been seen by decode for exactly one cycle.
  3. stall
     - imem_addr=pc (re-read the same word); pc, inst_id, pc_id, valid_id all held.
  4. otherwise
     - imem_addr=pc+1; pc<=pc+1.
     - inst_id<=imem_rdata; pc_id<=pc+1; valid_id<=1.
- HALTED:
  - imem_addr=pc; all registers held; valid_id=0; halted=1.
  - Exits only via reset. flush and stall are ignored.
- Invariant: `imem_rdata` always corresponds to the current pc in RUN.
- Arithmetic: pc+1 is modulo 2^PC_W; 16'hFFFF wraps to 0 with no flag.
- is_halt with valid_id=0 (bubble) is ignored.
- Reset asserted mid-operation: immediate return to reset values, regardless of state or stall/flush.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - perf_fetched increments on each RUN cycle that loads a valid instruction.
  - perf_stall increments on each RUN cycle with stall=1 and flush=0.
  - Both counters freeze in HALTED.
- Undefined: ports and counters are absent; all other behaviour identical.

Decomposition:
- Shared package simple_pkg holds:
  - NOP_INST=16'hC070 and HALT_INST=16'hC0F0.
  - fetch_state_t enum {FILL, RUN, HALTED}.
  - PC_W/INST_W defaults.
- Sub-module if_id_reg: IF/ID register with load/hold/bubble control and async reset; fetch_stage instantiates it.

Test Plan:
- Reset release, memory word i = 16'h1000+i, no stall/flush → valid_id rises 2 cycles after reset release; inst_id sequence 1000, 1001, 1002 with pc_id 1, 2, 3; imem_addr leads by one.
- stall held 3 cycles while inst_id=16'h1002 → inst_id/pc_id/valid_id unchanged for 3 cycles, imem_addr constant; after release the next inst_id is 16'h1003 with no word skipped or duplicated.
- flush with branch_target=16'h0040, stall=1 in the same cycle → next cycle valid_id=0 and inst_id=C070; the following cycle inst_id=mem[0x40], pc_id=0x41.
- Memory word 3 = C0F0, decode drives is_halt when it is in inst_id → halted=1 next cycle, valid_id=0 thereafter, imem_addr frozen; later flush/stall pulses cause no change.
- pc driven to 16'hFFFF via flush → next fetch address 16'h0000, pc_id of the FFFF instruction = 0.
- Reset asserted mid-RUN and mid-HALTED → outputs return to reset values asynchronously (before the next edge); FILL is re-entered on release. With FETCH_PERF_EN defined, both counters read 0.
